alu_iter: RTL and testbench

Parametrised iterative integer ALU for the multi-cycle RISC-V core, successor to the fixed 32-bit, 1-bit-per-cycle sequential ALU. It latches its operands on `start` and runs internally, with no datapath feedback of partial results. It supports a configurable XLEN (32/64), a configurable shift step (bits shifted per cycle), Zba shift-add, branch compare, and RV64 word (`*W`) operations. It sits between the datapath operand registers and the PC/rd write-back muxes.

---
 rtl/alu_iter.sv | 206 ++++++++++++++++++++
 tb/tb_alu_iter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_iter.sv
// alu_iter: parametrised iterative integer ALU for the multi-cycle RISC-V core.
// Operands are latched on an accepted start. Single-cycle ops (add/sub,
// compare, logic, Zba shift-add, branch compare) land in `out` one cycle
// later. Shifts walk the accumulator SHIFT_STEP bits per cycle. On RV64, word
// ops work on the low 32 bits and sign-extend the result from bit 31.
module alu_iter #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1,
    parameter int SHAMT_W    = $clog2(XLEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [XLEN-1:0]    src_a,
    input  logic [XLEN-1:0]    src_b,
    input  logic [2:0]         f3,
    input  logic               arith_bit,
    input  logic               shadd,
    input  logic               branch,
    input  logic               word_op,
    output logic [XLEN-1:0]    out,
    output logic [SHAMT_W-1:0] shamt_out,
    output logic               done,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // One extra bit so that SHIFT_STEP == XLEN is still representable.
    localparam logic [SHAMT_W:0] STEP_AMT = (SHAMT_W+1)'(SHIFT_STEP);

    state_t              state, state_next;
    logic [XLEN-1:0]     acc, acc_next;
    logic [SHAMT_W-1:0]  shamt, shamt_next;
    logic                sh_left, sh_left_next;
    logic                sh_arith, sh_arith_next;
    logic                sh_word, sh_word_next;

    logic                word_en;
    logic                is_shift;
    logic                lt_s, lt_u, eq;
    logic                taken;
    logic [XLEN-1:0]     sum;
    logic [XLEN-1:0]     alu_result;
    logic [SHAMT_W-1:0]  s_in;
    logic [XLEN-1:0]     shift_load;
    logic [SHAMT_W:0]    step_amt;
    logic [XLEN-1:0]     shifted;
    logic [SHAMT_W-1:0]  shamt_dec;

    // Replace everything above bit 31 with copies of bit 31.
    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] x);
        logic [XLEN-1:0] r;
        r = x;
        for (int i = 32; i < XLEN; i++) r[i] = x[31];
        return r;
    endfunction

    // Clear everything above bit 31.
    function automatic logic [XLEN-1:0] zext32(input logic [XLEN-1:0] x);
        logic [XLEN-1:0] r;
        r = x;
        for (int i = 32; i < XLEN; i++) r[i] = 1'b0;
        return r;
    endfunction

    assign word_en   = (XLEN == 64) && word_op;
    assign is_shift  = !branch && (f3[1:0] == 2'b01);
    assign lt_s      = $signed(src_a) < $signed(src_b);
    assign lt_u      = src_a < src_b;
    assign eq        = src_a == src_b;
    assign done      = (state == DONE);
    assign busy      = (state == SHIFT);
    assign out       = acc;
    assign shamt_out = shamt;

    // Single-cycle result: branch compare wins, then Zba shift-add, then the
    // plain register-register ops.
    always_comb begin
        alu_result = '0;
        taken      = 1'b0;
        sum        = arith_bit ? (src_a - src_b) : (src_a + src_b);
        if (branch) begin
            case (f3)
                3'b000:  taken = eq;
                3'b001:  taken = !eq;
                3'b100:  taken = lt_s;
                3'b101:  taken = !lt_s;
                3'b110:  taken = lt_u;
                3'b111:  taken = !lt_u;
                default: taken = 1'b0;
            endcase
            alu_result = {XLEN{taken}};
        end else if (shadd && (f3 == 3'b010 || f3 == 3'b100 || f3 == 3'b110)) begin
            case (f3)
                3'b010:  alu_result = (src_a << 1) + src_b;
                3'b100:  alu_result = (src_a << 2) + src_b;
                default: alu_result = (src_a << 3) + src_b;
            endcase
        end else begin
            case (f3)
                3'b000:  alu_result = word_en ? sext32(sum) : sum;
                3'b010:  alu_result[0] = lt_s;
                3'b011:  alu_result[0] = lt_u;
                3'b100:  alu_result = src_a ^ src_b;
                3'b110:  alu_result = src_a | src_b;
                3'b111:  alu_result = src_a & src_b;
                default: alu_result = '0;
            endcase
        end
    end

    // Shift setup from the inputs: amount and the value the accumulator
    // starts from (word right shifts pre-extend the low word).
    always_comb begin
        s_in = '0;
        if (word_en) s_in[4:0] = src_b[4:0];
        else         s_in      = src_b[SHAMT_W-1:0];
        if (word_en) shift_load = (f3[2] && arith_bit) ? sext32(src_a) : zext32(src_a);
        else         shift_load = src_a;
    end

    // One shift step: min(SHIFT_STEP, remaining) bits in the latched direction.
    always_comb begin
        step_amt = ({1'b0, shamt} < STEP_AMT) ? {1'b0, shamt} : STEP_AMT;
        if (sh_left)       shifted = acc << step_amt;
        else if (sh_arith) shifted = $signed(acc) >>> step_amt;
        else               shifted = acc >> step_amt;
        shamt_dec = shamt - step_amt[SHAMT_W-1:0];
    end

    // Next-state and next-datapath logic; start is only honoured outside SHIFT.
    always_comb begin
        state_next    = state;
        acc_next      = acc;
        shamt_next    = shamt;
        sh_left_next  = sh_left;
        sh_arith_next = sh_arith;
        sh_word_next  = sh_word;
        case (state)
            IDLE, DONE: begin
                state_next = IDLE;
                if (start) begin
                    if (is_shift) begin
                        sh_left_next  = !f3[2];
                        sh_arith_next = f3[2] && arith_bit;
                        sh_word_next  = word_en;
                        if (s_in == '0) begin
                            acc_next   = word_en ? sext32(src_a) : src_a;
                            shamt_next = '0;
                            state_next = DONE;
                        end else begin
                            acc_next   = shift_load;
                            shamt_next = s_in;
                            state_next = SHIFT;
                        end
                    end else begin
                        acc_next   = alu_result;
                        shamt_next = '0;
                        state_next = DONE;
                    end
                end
            end
            SHIFT: begin
                acc_next   = shifted;
                shamt_next = shamt_dec;
                if (shamt_dec == '0) begin
                    state_next = DONE;
                    if (sh_word) acc_next = sext32(shifted);
                end
            end
            default: begin
                state_next = IDLE;
                shamt_next = '0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Accumulator, remaining shift count and latched shift flavour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            shamt    <= '0;
            sh_left  <= 1'b0;
            sh_arith <= 1'b0;
            sh_word  <= 1'b0;
        end else begin
            acc      <= acc_next;
            shamt    <= shamt_next;
            sh_left  <= sh_left_next;
            sh_arith <= sh_arith_next;
            sh_word  <= sh_word_next;
        end
    end

endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: scoreboard bench for alu_iter in three configurations
// (32-bit step 1, 32-bit step 4, 64-bit step 8). Stimulus pushes expected
// results and latencies; a negedge monitor pops them whenever done pulses.
module tb_alu_iter;

    typedef struct {
        logic [63:0] expv;
        int          lat;
        int          issue;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start0, start1, start2;
    logic [63:0] src_a, src_b;
    logic [2:0]  f3;
    logic        arith_bit, shadd, branch, word_op;

    logic [31:0] out0, out1;
    logic [63:0] out2;
    logic [4:0]  shamt0, shamt1;
    logic [5:0]  shamt2;
    logic        done0, done1, done2;
    logic        busy0, busy1, busy2;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    exp_t  q0[$], q1[$], q2[$];
    string n0[$], n1[$], n2[$];

    logic [31:0] sra_part [4];

    alu_iter #(.XLEN(32), .SHIFT_STEP(1)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0),
        .src_a(src_a[31:0]), .src_b(src_b[31:0]), .f3(f3),
        .arith_bit(arith_bit), .shadd(shadd), .branch(branch), .word_op(word_op),
        .out(out0), .shamt_out(shamt0), .done(done0), .busy(busy0)
    );

    alu_iter #(.XLEN(32), .SHIFT_STEP(4)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .src_a(src_a[31:0]), .src_b(src_b[31:0]), .f3(f3),
        .arith_bit(arith_bit), .shadd(shadd), .branch(branch), .word_op(word_op),
        .out(out1), .shamt_out(shamt1), .done(done1), .busy(busy1)
    );

    alu_iter #(.XLEN(64), .SHIFT_STEP(8)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2),
        .src_a(src_a), .src_b(src_b), .f3(f3),
        .arith_bit(arith_bit), .shadd(shadd), .branch(branch), .word_op(word_op),
        .out(out2), .shamt_out(shamt2), .done(done2), .busy(busy2)
    );

    // 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to measure start-to-done latency.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Pop the oldest expectation for DUT d and compare result and latency.
    task automatic popCheck(input int d, input logic [63:0] actual);
        exp_t  e;
        string nm;
        logic  found;
        found = 1'b0;
        e.expv = '0; e.lat = 0; e.issue = 0;
        nm = "";
        case (d)
            0: if (q0.size() > 0) begin e = q0.pop_front(); nm = n0.pop_front(); found = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); nm = n1.pop_front(); found = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); nm = n2.pop_front(); found = 1'b1; end
        endcase
        if (!found) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected_done_d%0d: got out 0x%0h, expected no done", d, actual);
        end else begin
            checkOutput({nm, "_out"}, actual, e.expv);
            checkOutput({nm, "_lat"}, 64'(cyc - e.issue + 1), 64'(e.lat));
        end
    endtask

    // Monitor: whenever a DUT presents done, check it against the scoreboard.
    always @(negedge clk) begin
        if (done0) popCheck(0, {32'b0, out0});
        if (done1) popCheck(1, {32'b0, out1});
        if (done2) popCheck(2, out2);
    end

    // Drive one operation into DUT d and record what it must return.
    task automatic applyStimulus(input int d, input string name, input logic [2:0] op,
                                 input logic ar, input logic sa, input logic br,
                                 input logic wd, input logic [63:0] a, input logic [63:0] b,
                                 input logic [63:0] expv, input int lat);
        exp_t e;
        f3 = op; arith_bit = ar; shadd = sa; branch = br; word_op = wd;
        src_a = a; src_b = b;
        case (d)
            0:       start0 = 1'b1;
            1:       start1 = 1'b1;
            default: start2 = 1'b1;
        endcase
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        e.expv = expv; e.lat = lat; e.issue = cyc;
        case (d)
            0:       begin q0.push_back(e); n0.push_back(name); end
            1:       begin q1.push_back(e); n1.push_back(name); end
            default: begin q2.push_back(e); n2.push_back(name); end
        endcase
    endtask

    task automatic waitDone(input int d, input int budget, input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk); #1;
            seen = (d == 0) ? done0 : (d == 1) ? done1 : done2;
        end
        if (!seen) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s: got no done within %0d cycles, expected done", name, budget);
        end
    endtask

    task automatic waitDrain(input int budget);
        int i;
        i = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && i < budget) begin
            @(negedge clk); #1;
            i++;
        end
        if ((q0.size() + q1.size() + q2.size()) != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain: got %0d results outstanding, expected 0",
                     q0.size() + q1.size() + q2.size());
            q0.delete(); q1.delete(); q2.delete();
            n0.delete(); n1.delete(); n2.delete();
        end
    endtask

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        sra_part[0] = 32'h8000_0000;
        sra_part[1] = 32'hC000_0000;
        sra_part[2] = 32'hE000_0000;
        sra_part[3] = 32'hF000_0000;

        rst = 1'b1;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        src_a = '0; src_b = '0; f3 = '0;
        arith_bit = 1'b0; shadd = 1'b0; branch = 1'b0; word_op = 1'b0;

        // Reset state of all three configurations.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out0", {32'b0, out0}, 64'h0);
        checkOutput("rst_out1", {32'b0, out1}, 64'h0);
        checkOutput("rst_out2", out2, 64'h0);
        checkOutput("rst_shamt", 64'({shamt0, shamt1, shamt2}), 64'h0);
        checkOutput("rst_flags", 64'({done0, busy0, done1, busy1, done2, busy2}), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // SRA step 1: partial accumulator and remaining count every cycle.
        applyStimulus(0, "sra_step1", 3'b101, 1, 0, 0, 0, 64'h8000_0000, 64'd4, 64'hF800_0000, 5);
        for (int j = 0; j < 4; j++) begin
            checkOutput($sformatf("sra_busy_c%0d", j + 1), 64'(busy0), 64'd1);
            checkOutput($sformatf("sra_shamt_c%0d", j + 1), 64'(shamt0), 64'(4 - j));
            checkOutput($sformatf("sra_part_c%0d", j + 1), {32'b0, out0}, {32'b0, sra_part[j]});
            if (j < 3) begin
                @(posedge clk); #1;
            end
        end
        waitDrain(20);

        // Zero shift amount (bit 5 of B is outside the 32-bit amount).
        applyStimulus(0, "sll_zero", 3'b001, 0, 0, 0, 0, 64'h1234_5678, 64'h20, 64'h1234_5678, 1);
        checkOutput("sll_zero_busy", 64'(busy0), 64'd0);
        waitDrain(20);

        // Back-to-back single-cycle ops.
        applyStimulus(0, "add",  3'b000, 0, 0, 0, 0, 64'd5, 64'd7, 64'd12, 1);
        applyStimulus(0, "sub",  3'b000, 1, 0, 0, 0, 64'd3, 64'd5, 64'hFFFF_FFFE, 1);
        applyStimulus(0, "slt",  3'b010, 0, 0, 0, 0, 64'hFFFF_FFFE, 64'd1, 64'd1, 1);
        applyStimulus(0, "sltu", 3'b011, 0, 0, 0, 0, 64'hFFFF_FFFE, 64'd1, 64'd0, 1);
        applyStimulus(0, "xor",  3'b100, 0, 0, 0, 0, 64'hF0F0_F0F0, 64'hFF00_FF00, 64'h0FF0_0FF0, 1);
        applyStimulus(0, "or",   3'b110, 0, 0, 0, 0, 64'hF0F0_F0F0, 64'h0F0F_0000, 64'hFFFF_F0F0, 1);
        applyStimulus(0, "and",  3'b111, 0, 0, 0, 0, 64'hF0F0_F0F0, 64'hFF00_FF00, 64'hF000_F000, 1);
        waitDrain(20);

        // Zba shift-add and branch compares (0xFFFFFFFF is -1 signed, max unsigned).
        applyStimulus(0, "sh2add", 3'b100, 0, 1, 0, 0, 64'd3, 64'd10, 64'd22, 1);
        applyStimulus(0, "sh1add", 3'b010, 0, 1, 0, 0, 64'd5, 64'd1, 64'd11, 1);
        applyStimulus(0, "sh3add", 3'b110, 0, 1, 0, 0, 64'd2, 64'hFFFF_FFFF, 64'd15, 1);
        applyStimulus(0, "blt",    3'b100, 0, 1, 1, 0, 64'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF, 1);
        applyStimulus(0, "bgeu",   3'b111, 0, 0, 1, 0, 64'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF, 1);
        applyStimulus(0, "bltu",   3'b110, 0, 0, 1, 0, 64'hFFFF_FFFF, 64'd1, 64'd0, 1);
        applyStimulus(0, "bge",    3'b101, 0, 0, 1, 0, 64'hFFFF_FFFF, 64'd1, 64'd0, 1);
        applyStimulus(0, "beq",    3'b000, 1, 0, 1, 0, 64'd7, 64'd7, 64'hFFFF_FFFF, 1);
        applyStimulus(0, "bne",    3'b001, 0, 0, 1, 0, 64'd7, 64'd7, 64'd0, 1);
        applyStimulus(0, "br010",  3'b010, 0, 0, 1, 0, 64'd7, 64'd7, 64'd0, 1);
        waitDrain(20);

        // SLL step 4 with a final 3-bit step; a start mid-shift must be ignored.
        applyStimulus(1, "sll_step4", 3'b001, 0, 0, 0, 0, 64'd1, 64'd31, 64'h8000_0000, 9);
        for (int j = 1; j <= 8; j++) begin
            checkOutput($sformatf("sll4_shamt_c%0d", j), 64'(shamt1), 64'(31 - 4 * (j - 1)));
            checkOutput($sformatf("sll4_busy_c%0d", j), 64'(busy1), 64'd1);
            if (j == 3) begin
                f3 = 3'b000; arith_bit = 1'b0; src_a = 64'd9; src_b = 64'd9;
                start1 = 1'b1;
            end
            if (j == 4) start1 = 1'b0;
            if (j < 8) begin
                @(posedge clk); #1;
            end
        end
        waitDone(1, 4, "sll_step4_done");
        applyStimulus(1, "sub_in_done", 3'b000, 1, 0, 0, 0, 64'd0, 64'd1, 64'hFFFF_FFFF, 1);
        waitDrain(20);

        // RV64 word ops and full-width shifts with step 8.
        applyStimulus(2, "sraw", 3'b101, 1, 0, 0, 1, 64'h0000_0000_8000_0000, 64'h21,
                      64'hFFFF_FFFF_C000_0000, 2);
        waitDrain(20);
        applyStimulus(2, "addw", 3'b000, 0, 0, 0, 1, 64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000, 1);
        applyStimulus(2, "add64", 3'b000, 0, 0, 0, 0, 64'h7FFF_FFFF, 64'd1, 64'h0000_0000_8000_0000, 1);
        applyStimulus(2, "subw", 3'b000, 1, 0, 0, 1, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        applyStimulus(2, "sltu_w", 3'b011, 0, 0, 0, 1, 64'hFFFF_FFFF_0000_0000, 64'd1, 64'd0, 1);
        waitDrain(20);
        applyStimulus(2, "srlw", 3'b101, 0, 0, 0, 1, 64'hFFFF_FFFF_8000_0000, 64'd4,
                      64'h0000_0000_0800_0000, 2);
        waitDrain(20);
        applyStimulus(2, "sllw", 3'b001, 0, 0, 0, 1, 64'd1, 64'd31, 64'hFFFF_FFFF_8000_0000, 5);
        waitDrain(20);
        applyStimulus(2, "sra64", 3'b101, 1, 0, 0, 0, 64'h8000_0000_0000_0000, 64'd63,
                      64'hFFFF_FFFF_FFFF_FFFF, 9);
        waitDrain(20);
        applyStimulus(2, "srl64", 3'b101, 0, 0, 0, 0, 64'h8000_0000_0000_0000, 64'd60, 64'h8, 9);
        waitDrain(20);
        applyStimulus(2, "srlw_zero", 3'b101, 0, 0, 0, 1, 64'h8000_0000, 64'h20,
                      64'hFFFF_FFFF_8000_0000, 1);
        waitDrain(20);

        // Reset in the middle of a shift: immediate clear, no done, then recover.
        f3 = 3'b101; arith_bit = 1'b1; shadd = 1'b0; branch = 1'b0; word_op = 1'b0;
        src_a = 64'h8000_0000; src_b = 64'd8;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        @(posedge clk); #1;
        checkOutput("abort_busy_before", 64'(busy0), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("abort_out", {32'b0, out0}, 64'h0);
        checkOutput("abort_shamt", 64'(shamt0), 64'h0);
        checkOutput("abort_flags", 64'({done0, busy0}), 64'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        applyStimulus(0, "srl_after_rst", 3'b101, 0, 0, 0, 0, 64'h8000_0000, 64'd8,
                      64'h0080_0000, 9);
        waitDrain(30);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
